// File: rtl/multi_cycle_execute_stage4_pkg.sv
// Shared execute-pipeline types: thread/subcycle indices, ALU opcodes and the decoded instruction.
package multi_cycle_execute_stage4_pkg;

  localparam int VECTOR_LANES = 16;

  typedef logic [1:0]  thread_idx_t;
  typedef logic [3:0]  subcycle_t;
  typedef logic [31:0] scalar_t;

  typedef enum logic [5:0] {
    OP_IMUL = 6'h07,
    OP_FADD = 6'h20,
    OP_FSUB = 6'h21,
    OP_FMUL = 6'h22,
    OP_FTOI = 6'h2a
  } alu_op_t;

  typedef struct packed {
    logic        has_dest;
    logic [4:0]  dest_reg;
    logic        dest_is_vector;
    alu_op_t     alu_op;
    logic        has_mask;
    logic [1:0]  pipeline_sel;
  } decoded_instruction_t;

endpackage

// File: rtl/multi_cycle_execute_stage4_clz32.sv
// Combinational 32-bit leading-zero counter; an all-zero input reports 32.
module multi_cycle_execute_stage4_clz32 (
  input  logic [31:0] value,
  output logic [5:0]  count
);

  // Scan upward so the most significant set bit determines the count.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      count = value[i] ? 6'(31 - i) : count;
    end
  end

endmodule

// File: rtl/multi_cycle_execute_stage4.sv
// Execute stage 4: per-lane normalization shift for FP add/sub and registered operands for stage 5.
// Optional FP_SUBNORMAL_CLAMP_EN limits the shift so the stage-5 exponent never drops below 1.
module multi_cycle_execute_stage4
  import multi_cycle_execute_stage4_pkg::*;
#(
  parameter int LANES = VECTOR_LANES
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mx3_instruction_valid,
  input  decoded_instruction_t       mx3_instruction,
  input  thread_idx_t                mx3_thread_idx,
  input  subcycle_t                  mx3_subcycle,
  input  logic [LANES-1:0]           mx3_mask_value,
  input  logic [LANES-1:0]           mx3_result_is_inf,
  input  logic [LANES-1:0]           mx3_result_is_nan,
  input  logic [LANES-1:0][7:0]      mx3_add_exponent,
  input  logic [LANES-1:0][31:0]     mx3_add_significand,
  input  logic [LANES-1:0]           mx3_add_result_sign,
  input  logic [LANES-1:0]           mx3_logical_subtract,
  input  logic [LANES-1:0][63:0]     mx3_significand_product,
  input  logic [LANES-1:0][7:0]      mx3_mul_exponent,
  input  logic [LANES-1:0]           mx3_mul_sign,
  input  logic                       wb_rollback_en,
  input  thread_idx_t                wb_rollback_thread_idx,
  output logic                       mx4_instruction_valid,
  output decoded_instruction_t       mx4_instruction,
  output thread_idx_t                mx4_thread_idx,
  output subcycle_t                  mx4_subcycle,
  output logic [LANES-1:0]           mx4_mask_value,
  output logic [LANES-1:0]           mx4_result_is_inf,
  output logic [LANES-1:0]           mx4_result_is_nan,
  output logic [LANES-1:0][7:0]      mx4_add_exponent,
  output logic [LANES-1:0][31:0]     mx4_add_significand,
  output logic [LANES-1:0]           mx4_add_result_sign,
  output logic [LANES-1:0]           mx4_logical_subtract,
  output logic [LANES-1:0][63:0]     mx4_significand_product,
  output logic [LANES-1:0][7:0]      mx4_mul_exponent,
  output logic [LANES-1:0]           mx4_mul_sign,
  output logic [LANES-1:0][5:0]      mx4_norm_shift
);

  logic [LANES-1:0][5:0] norm_shift;
  logic                  valid_next;

  for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
    logic [5:0] clz;
    logic [5:0] shift;

    multi_cycle_execute_stage4_clz32 u_clz (
      .value (mx3_add_significand[lane]),
      .count (clz)
    );

`ifdef FP_SUBNORMAL_CLAMP_EN
    logic [8:0] limit;

    // Cap the shift at exponent+7 so stage 5 lands on exponent 1 at worst; zero sums are exempt.
    always_comb begin
      limit = {1'b0, mx3_add_exponent[lane]} + 9'd7;
      if ((clz != 6'd32) && ({3'b000, clz} > limit)) begin
        shift = limit[5:0];
      end else begin
        shift = clz;
      end
    end
`else
    assign shift = clz;
`endif

    assign norm_shift[lane] = shift;
  end

  // Squash only the incoming instruction; one already in mx4 is downstream's responsibility.
  always_comb begin
    if (wb_rollback_en && (wb_rollback_thread_idx == mx3_thread_idx)) begin
      valid_next = 1'b0;
    end else begin
      valid_next = mx3_instruction_valid;
    end
  end

  // Pipeline register: data always captured, valid gated by rollback.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mx4_instruction_valid   <= 1'b0;
      mx4_instruction         <= '0;
      mx4_thread_idx          <= '0;
      mx4_subcycle            <= '0;
      mx4_mask_value          <= '0;
      mx4_result_is_inf       <= '0;
      mx4_result_is_nan       <= '0;
      mx4_add_exponent        <= '0;
      mx4_add_significand     <= '0;
      mx4_add_result_sign     <= '0;
      mx4_logical_subtract    <= '0;
      mx4_significand_product <= '0;
      mx4_mul_exponent        <= '0;
      mx4_mul_sign            <= '0;
      mx4_norm_shift          <= '0;
    end else begin
      mx4_instruction_valid   <= valid_next;
      mx4_instruction         <= mx3_instruction;
      mx4_thread_idx          <= mx3_thread_idx;
      mx4_subcycle            <= mx3_subcycle;
      mx4_mask_value          <= mx3_mask_value;
      mx4_result_is_inf       <= mx3_result_is_inf;
      mx4_result_is_nan       <= mx3_result_is_nan;
      mx4_add_exponent        <= mx3_add_exponent;
      mx4_add_significand     <= mx3_add_significand;
      mx4_add_result_sign     <= mx3_add_result_sign;
      mx4_logical_subtract    <= mx3_logical_subtract;
      mx4_significand_product <= mx3_significand_product;
      mx4_mul_exponent        <= mx3_mul_exponent;
      mx4_mul_sign            <= mx3_mul_sign;
      mx4_norm_shift          <= norm_shift;
    end
  end

endmodule

// File: tb/tb_multi_cycle_execute_stage4.sv
// Scoreboard bench for multi_cycle_execute_stage4: driver pushes expected records, negedge monitor pops and compares.
module tb_multi_cycle_execute_stage4;
  import multi_cycle_execute_stage4_pkg::*;

  localparam int L = 16;

  typedef struct packed {
    logic        inf;
    logic        nan;
    logic [7:0]  aexp;
    logic [31:0] asig;
    logic        asign;
    logic        lsub;
    logic [63:0] prod;
    logic [7:0]  mexp;
    logic        msign;
  } lane_t;

  typedef struct {
    logic        valid;
    logic [37:0] hdr;
    lane_t       ln [L];
    logic [5:0]  ns [L];
  } rec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic                   i_valid;
  decoded_instruction_t   i_instr;
  thread_idx_t            i_thread;
  subcycle_t              i_sub;
  logic [L-1:0]           i_mask, i_inf, i_nan, i_asign, i_lsub, i_msign;
  logic [L-1:0][7:0]      i_aexp, i_mexp;
  logic [L-1:0][31:0]     i_asig;
  logic [L-1:0][63:0]     i_prod;
  logic                   rb_en;
  thread_idx_t            rb_thread;

  logic                   o_valid;
  decoded_instruction_t   o_instr;
  thread_idx_t            o_thread;
  subcycle_t              o_sub;
  logic [L-1:0]           o_mask, o_inf, o_nan, o_asign, o_lsub, o_msign;
  logic [L-1:0][7:0]      o_aexp, o_mexp;
  logic [L-1:0][31:0]     o_asig;
  logic [L-1:0][63:0]     o_prod;
  logic [L-1:0][5:0]      o_ns;

  multi_cycle_execute_stage4 #(.LANES(L)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .mx3_instruction_valid   (i_valid),
    .mx3_instruction         (i_instr),
    .mx3_thread_idx          (i_thread),
    .mx3_subcycle            (i_sub),
    .mx3_mask_value          (i_mask),
    .mx3_result_is_inf       (i_inf),
    .mx3_result_is_nan       (i_nan),
    .mx3_add_exponent        (i_aexp),
    .mx3_add_significand     (i_asig),
    .mx3_add_result_sign     (i_asign),
    .mx3_logical_subtract    (i_lsub),
    .mx3_significand_product (i_prod),
    .mx3_mul_exponent        (i_mexp),
    .mx3_mul_sign            (i_msign),
    .wb_rollback_en          (rb_en),
    .wb_rollback_thread_idx  (rb_thread),
    .mx4_instruction_valid   (o_valid),
    .mx4_instruction         (o_instr),
    .mx4_thread_idx          (o_thread),
    .mx4_subcycle            (o_sub),
    .mx4_mask_value          (o_mask),
    .mx4_result_is_inf       (o_inf),
    .mx4_result_is_nan       (o_nan),
    .mx4_add_exponent        (o_aexp),
    .mx4_add_significand     (o_asig),
    .mx4_add_result_sign     (o_asign),
    .mx4_logical_subtract    (o_lsub),
    .mx4_significand_product (o_prod),
    .mx4_mul_exponent        (o_mexp),
    .mx4_mul_sign            (o_msign),
    .mx4_norm_shift          (o_ns)
  );

  int checks = 0;
  int failures = 0;
  rec_t exp_q[$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference: shift left until the MSB is set; zero means 32.
  function automatic logic [5:0] ref_shift(input logic [31:0] sig, input logic [7:0] e);
    int n;
    logic [31:0] s;
    if (sig == 32'd0) return 6'd32;
    n = 0;
    s = sig;
    while (s[31] == 1'b0) begin
      s = s << 1;
      n++;
    end
`ifdef FP_SUBNORMAL_CLAMP_EN
    if (n > int'(e) + 7) n = int'(e) + 7;
`else
    if (e == 8'd0) n = n;
`endif
    return 6'(n);
  endfunction

  task automatic push_expected();
    rec_t r;
    r.valid = i_valid && !(rb_en && (rb_thread == i_thread));
    r.hdr   = {i_instr, i_thread, i_sub, i_mask};
    for (int l = 0; l < L; l++) begin
      r.ln[l] = lane_t'({i_inf[l], i_nan[l], i_aexp[l], i_asig[l], i_asign[l], i_lsub[l],
                         i_prod[l], i_mexp[l], i_msign[l]});
      r.ns[l] = ref_shift(i_asig[l], i_aexp[l]);
    end
    exp_q.push_back(r);
  endtask

  task automatic next_slot();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    i_valid   = 1'($urandom_range(0, 1));
    i_instr   = decoded_instruction_t'(16'($urandom));
    i_thread  = thread_idx_t'($urandom_range(0, 3));
    i_sub     = subcycle_t'($urandom);
    i_mask    = 16'($urandom);
    i_inf     = 16'($urandom);
    i_nan     = 16'($urandom);
    i_asign   = 16'($urandom);
    i_lsub    = 16'($urandom);
    i_msign   = 16'($urandom);
    for (int l = 0; l < L; l++) begin
      i_aexp[l] = 8'($urandom);
      i_mexp[l] = 8'($urandom);
      i_asig[l] = 32'($urandom) >> $urandom_range(0, 32);
      i_prod[l] = {32'($urandom), 32'($urandom)};
    end
    rb_en     = ($urandom_range(0, 3) == 0);
    rb_thread = thread_idx_t'($urandom_range(0, 3));
  endtask

  function automatic logic all_outputs_zero();
    return ({o_valid, o_instr, o_thread, o_sub, o_mask, o_inf, o_nan, o_aexp, o_asig, o_asign,
             o_lsub, o_prod, o_mexp, o_msign, o_ns} == '0);
  endfunction

  // Monitor: every cycle out of reset with a pending record is one DUT output slot.
  always @(negedge clk) begin
    rec_t  r;
    lane_t g;
    if (reset_n && (exp_q.size() > 0)) begin
      r = exp_q.pop_front();
      chk("valid", 128'(o_valid), 128'(r.valid));
      chk("header", 128'({o_instr, o_thread, o_sub, o_mask}), 128'(r.hdr));
      for (int l = 0; l < L; l++) begin
        g = lane_t'({o_inf[l], o_nan[l], o_aexp[l], o_asig[l], o_asign[l], o_lsub[l],
                     o_prod[l], o_mexp[l], o_msign[l]});
        chk($sformatf("lane%0d_data", l), 128'(g), 128'(r.ln[l]));
        chk($sformatf("lane%0d_norm_shift", l), 128'(o_ns[l]), 128'(r.ns[l]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b1;
    rand_inputs();
    #1 reset_n = 1'b0;

    // Reset holds outputs at zero despite random valid inputs.
    for (int c = 0; c < 3; c++) begin
      next_slot();
      rand_inputs();
      i_valid = 1'b1;
      rb_en   = 1'b0;
      @(negedge clk);
      chk("reset_valid", 128'(o_valid), 128'(0));
      chk("reset_all_zero", 128'(all_outputs_zero()), 128'(1));
    end
    #1 reset_n = 1'b1;

    // First FADD after reset.
    rand_inputs();
    i_valid = 1'b1; i_instr.alu_op = OP_FADD; rb_en = 1'b0;
    push_expected();

    // CLZ sweep: lane k = 0x8000_0000 >> k, then a zero lane and 0x1.
    next_slot();
    rand_inputs();
    i_valid = 1'b1; i_instr.alu_op = OP_FSUB; rb_en = 1'b0;
    for (int k = 0; k < L; k++) begin
      i_asig[k] = 32'h8000_0000 >> k;
      i_aexp[k] = 8'd100;
    end
    push_expected();
    next_slot();
    i_asig[0] = 32'd0;
    i_asig[1] = 32'h0000_0001;
    i_aexp[1] = 8'd200;
    push_expected();

    // Pass-through on the multiply path.
    next_slot();
    rand_inputs();
    i_valid = 1'b1; i_instr.alu_op = OP_FMUL; rb_en = 1'b0;
    i_mask = 16'hA5C3; i_inf = 16'h0F0F; i_nan = 16'h8001;
    for (int l = 0; l < L; l++) begin
      i_prod[l] = 64'h0000_4000_0000_0000;
      i_mexp[l] = 8'h85;
    end
    i_msign = 16'hFFFF;
    push_expected();

    // Rollback of the same thread squashes; a different thread does not.
    next_slot();
    i_valid = 1'b1; i_thread = 2'd2; rb_en = 1'b1; rb_thread = 2'd2;
    push_expected();
    next_slot();
    rb_thread = 2'd1;
    push_expected();
    next_slot();
    i_valid = 1'b0; rb_thread = 2'd2;
    push_expected();

    // Back-to-back threads 0..3, no bubbles.
    for (int t = 0; t < 4; t++) begin
      next_slot();
      rand_inputs();
      i_valid = 1'b1; i_thread = thread_idx_t'(t); rb_en = 1'b0;
      push_expected();
    end

    // Subnormal clamp case: exponent 2, clz 23.
    next_slot();
    rand_inputs();
    i_valid = 1'b1; i_instr.alu_op = OP_FADD; rb_en = 1'b0;
    i_aexp[0] = 8'd2;
    i_asig[0] = 32'h0000_0100;
    push_expected();

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      next_slot();
      rand_inputs();
      push_expected();
    end

    // Reset mid-operation drops the in-flight instruction.
    next_slot();
    rand_inputs();
    i_valid = 1'b1; rb_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midreset_valid", 128'(o_valid), 128'(0));
    @(negedge clk);
    chk("midreset_all_zero", 128'(all_outputs_zero()), 128'(1));
    #1 reset_n = 1'b1;
    rand_inputs();
    i_valid = 1'b1; rb_en = 1'b0;
    push_expected();

    for (int c = 0; c < 50; c++) begin
      next_slot();
      rand_inputs();
      push_expected();
    end

    next_slot();
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_execute_stage4.md
Name: multi_cycle_execute_stage4

Overview:
- Fourth stage of the multi-cycle (floating point / integer multiply) execute pipeline.
- Takes the raw adder sum and multiplier product from stage 3.
- Computes the per-lane leading-zero normalization shift for floating point add/subtract.
- Registers all operands for stage 5, which applies the shift, rounding and result select.
- Squashes instructions belonging to a thread that writeback is rolling back.

Parameters:
- LANES, 16, number of vector lanes (equals `VECTOR_LANES).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous reset, active low
- mx3_instruction_valid  in  1  stage 3 holds a valid instruction
- mx3_instruction  in  decoded_instruction_t  decoded instruction
- mx3_thread_idx  in  thread_idx_t  issuing thread
- mx3_subcycle  in  subcycle_t  subcycle number
- mx3_mask_value  in  LANES  lane enable mask
- mx3_result_is_inf  in  LANES  per-lane infinity flag
- mx3_result_is_nan  in  LANES  per-lane NaN flag
- mx3_add_exponent  in  LANES x 8  pre-normalization exponent
- mx3_add_significand  in  LANES x 32  unnormalized sum; hidden bit belongs at bit 31
- mx3_add_result_sign  in  LANES  sum sign
- mx3_logical_subtract  in  LANES  operation was an effective subtract
- mx3_significand_product  in  LANES x 64  multiplier product
- mx3_mul_exponent  in  LANES x 8  product exponent
- mx3_mul_sign  in  LANES  product sign
- wb_rollback_en  in  1  writeback rollback request
- wb_rollback_thread_idx  in  thread_idx_t  thread being rolled back
- mx4_instruction_valid  out  1  registered valid
- mx4_instruction, mx4_thread_idx, mx4_subcycle, mx4_mask_value  out  as inputs  registered copies
- mx4_result_is_inf, mx4_result_is_nan, mx4_add_exponent, mx4_add_significand, mx4_add_result_sign, mx4_logical_subtract, mx4_significand_product, mx4_mul_exponent, mx4_mul_sign  out  as inputs  registered copies
- mx4_norm_shift  out  LANES x 6  per-lane left shift amount

Behaviour:
- Single register stage, latency 1 cycle, no stall input.
- A new instruction may be accepted every cycle.
- Reset (reset_n low, asynchronous): every output register clears to 0, including mx4_instruction_valid.
- Release of reset is synchronous to clk.
- Reset asserted mid-operation drops any in-flight instruction; it is not replayed.
- Normalization shift, per lane: norm_shift = count of leading zeros of mx3_add_significand[31:0].
  - Range 0..31.
  - An all-zero significand yields 32 (6'd32).
  - Example: bit 31 set gives 0; 32'h0000_0001 gives 31.
  - Stage 5 computes exponent as add_exponent - norm_shift + 8 (8-bit wraparound). This stage never alters the exponent.
- Shift is computed for every lane regardless of alu_op or mask.
- Masked-off lanes pass data through unchanged; stage 5 and writeback honour the mask.
- The FTOI and IMUL paths pass significand and product through unmodified.
- Rollback squash:
  - If wb_rollback_en is high and wb_rollback_thread_idx == mx3_thread_idx, mx4_instruction_valid is written 0 on the next edge.
  - Data fields still register.
  - An instruction already in the mx4 register is not squashed by this stage; downstream handles it.
  - Rollback of a different thread has no effect.
- Simultaneous rollback and an invalid mx3 input: valid stays 0.

Optional Feature:
- Macro: FP_SUBNORMAL_CLAMP_EN.
- Defined: norm_shift = min(clz, add_exponent + 7), computed in 9 bits.
  - The stage-5 exponent therefore never drops below 1 for nonzero sums.
  - Results that would underflow are left partially normalized as the smallest-exponent encoding.
- Undefined: norm_shift = raw clz; underflow wraps in stage 5 (current behaviour).
- Zero significand (32) is never clamped.

Decomposition:
- decoded_instruction_t, thread_idx_t, subcycle_t, scalar_t, alu_op encodings and `VECTOR_LANES stay in the shared defines package.
- No new typedefs are required.
- One natural sub-module: clz32 (combinational 32-bit leading-zero counter, 6-bit output, 32 for zero input).
- clz32 is instantiated once per lane in a generate loop.

Test Plan:
- Reset: hold reset_n low with random inputs -> all outputs 0; release, then drive valid FADD -> mx4_instruction_valid = 1 exactly 1 cycle later.
- CLZ sweep: lane k significand = 32'h8000_0000 >> k for k = 0..15, plus significand 0 -> norm_shift = k, and 32 for the zero lane.
- Pass-through: product 64'h0000_4000_0000_0000, exponent 8'h85, sign 1, FMUL -> identical values at mx4 next cycle; inf/nan/mask bits preserved.
- Rollback: thread 2 valid with wb_rollback_en = 1, rollback thread 2 -> mx4_instruction_valid = 0; same with rollback thread 1 -> valid = 1.
- Back-to-back: 4 consecutive valid instructions (threads 0..3) -> outputs appear on 4 consecutive cycles in order, with no bubbles.
- With FP_SUBNORMAL_CLAMP_EN: exponent 8'd2, significand 32'h0000_0100 (clz 23) -> norm_shift = 9; without the macro -> 23.
